// File: rtl/rssb_pkg.sv
// Shared definitions for the RSSB core: FSM states and the special
// operand addresses that are decoded instead of going to memory.
package rssb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    OPER,
    EXEC,
    WB,
    OUTW,
    HALT
  } state_t;

  localparam int ADDR_PC   = 0;
  localparam int ADDR_ACC  = 1;
  localparam int ADDR_ZERO = 2;
  localparam int ADDR_IN   = 3;
  localparam int ADDR_OUT  = 4;

endpackage

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: r = v - acc, with the borrow flag taken
// from the sign bit of the result.
module rssb_alu
  import rssb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_v,
  input  logic [DATA_W-1:0] i_acc,
  output logic [DATA_W-1:0] o_r,
  output logic              o_neg
);

  assign o_r   = i_v - i_acc;
  assign o_neg = o_r[DATA_W-1];

endmodule

// File: rtl/rssb_core.sv
// One-instruction RSSB CPU core with a req/ack memory port, memory-mapped
// stream I/O, self-loop halt detection and a retired-instruction counter.
module rssb_core
  import rssb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int START_PC = 5,
  parameter int CNT_W    = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_halted,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_instr_count
);

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc;
  logic              r_neg;
  logic [ADDR_W-1:0] r_opAddr;
  logic [DATA_W-1:0] r_opVal;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_instrCount;

  logic [DATA_W-1:0] w_r;
  logic              w_neg;
  logic              w_isPc;
  logic              w_isAcc;
  logic              w_isIn;
  logic              w_isOut;
  logic              w_isMem;
  logic [DATA_W-1:0] w_specialVal;
  logic              w_retNeg;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_nextPc;
  logic              w_retire;

  rssb_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_v   (r_opVal),
    .i_acc (r_acc),
    .o_r   (w_r),
    .o_neg (w_neg)
  );

  assign w_isPc  = (r_opAddr == ADDR_W'(ADDR_PC));
  assign w_isAcc = (r_opAddr == ADDR_W'(ADDR_ACC));
  assign w_isIn  = (r_opAddr == ADDR_W'(ADDR_IN));
  assign w_isOut = (r_opAddr == ADDR_W'(ADDR_OUT));
  assign w_isMem = (r_opAddr >  ADDR_W'(ADDR_OUT));

  assign w_specialVal = w_isPc  ? DATA_W'(r_pc) :
                        w_isAcc ? r_acc         : '0;

  // Retirement in EXEC uses the live ALU result; WB/OUTW use the latched flag.
  assign w_retNeg = (r_state == EXEC) ? w_neg : r_neg;
  assign w_base   = ((r_state == EXEC) && w_isPc) ? w_r[ADDR_W-1:0] : r_pc;
  assign w_nextPc = w_base + ADDR_W'(1) + ADDR_W'(w_retNeg);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_pc;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_nextState = FETCH;
      end
      FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) w_nextState = OPER;
      end
      OPER: begin
        if (w_isMem) begin
          o_mem_req  = 1'b1;
          o_mem_addr = r_opAddr;
          if (i_mem_ack) w_nextState = EXEC;
        end else if (w_isIn) begin
          if (i_in_valid) begin
            o_in_ready  = 1'b1;
            w_nextState = EXEC;
          end
        end else begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (w_isMem) begin
          w_nextState = WB;
        end else if (w_isOut) begin
          w_nextState = OUTW;
        end else begin
          w_retire = 1'b1;
        end
      end
      WB: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = r_opAddr;
        if (i_mem_ack) w_retire = 1'b1;
      end
      OUTW: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_retire = 1'b1;
      end
      HALT: begin
        if (i_start) w_nextState = FETCH;
      end
      default: w_nextState = IDLE;
    endcase
    if (w_retire) begin
      w_nextState = (w_nextPc == r_pc) ? HALT : FETCH;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pc         <= START_ADDR;
      r_acc        <= '0;
      r_neg        <= 1'b0;
      r_opAddr     <= '0;
      r_opVal      <= '0;
      r_result     <= '0;
      r_instrCount <= '0;
    end else begin
      if (((r_state == IDLE) || (r_state == HALT)) && i_start) begin
        r_pc <= START_ADDR;
      end
      case (r_state)
        FETCH: begin
          if (i_mem_ack) r_opAddr <= i_mem_rdata[ADDR_W-1:0];
        end
        OPER: begin
          if (w_isMem) begin
            if (i_mem_ack) r_opVal <= i_mem_rdata;
          end else if (w_isIn) begin
            if (i_in_valid) r_opVal <= i_in_data;
          end else begin
            r_opVal <= w_specialVal;
          end
        end
        EXEC: begin
          r_acc    <= w_r;
          r_neg    <= w_neg;
          r_result <= w_r;
        end
        default: ;
      endcase
      if (w_retire) begin
        r_pc         <= w_nextPc;
        r_instrCount <= r_instrCount + CNT_W'(1);
      end
    end
  end

  assign o_mem_wdata   = r_result;
  assign o_out_data    = r_result;
  assign o_halted      = (r_state == HALT);
  assign o_busy        = (r_state != IDLE) && (r_state != HALT);
  assign o_instr_count = r_instrCount;

endmodule

// File: tb/tb_rssb_core.sv
// Scoreboard bench for rssb_core: directed programs run segment by segment,
// each ending in a self-loop halt that presets ACC for the next segment.
module tb_rssb_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic [15:0] memRdata;
  logic        memAck;
  logic [15:0] inData = 16'h1234;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        halted;
  logic        busy;
  logic [31:0] instrCount;

  logic [15:0] mem [0:65535];
  int          ackDelay = 0;
  logic        holdWrite = 1'b0;
  int          waitCnt = 0;

  int checks = 0;
  int errors = 0;
  int inPulses = 0;
  logic [31:0] lastCnt = '0;

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] pc;
    logic        halt;
  } retire_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } write_t;

  retire_t     retireQ[$];
  write_t      writeQ[$];
  logic [15:0] outQ[$];

  rssb_core #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .START_PC(5),
    .CNT_W   (32)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_start      (start),
    .o_mem_req    (memReq),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .i_mem_rdata  (memRdata),
    .i_mem_ack    (memAck),
    .i_in_data    (inData),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .o_out_data   (outData),
    .o_out_valid  (outValid),
    .i_out_ready  (outReady),
    .o_halted     (halted),
    .o_busy       (busy),
    .o_instr_count(instrCount)
  );

  always #5 clock = ~clock;

  // Variable-latency memory: ack after ackDelay waiting cycles, writes can be held off.
  assign memAck   = memReq && (waitCnt >= ackDelay) && !(memWe && holdWrite);
  assign memRdata = mem[memAddr];

  always @(posedge clock) begin
    if (memReq && memAck && memWe) mem[memAddr] <= memWdata;
    if (memReq && !memAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic loadWord(input logic [15:0] addr, input logic [15:0] data);
    mem[addr] <= data;
  endtask

  task automatic expRetire(input logic [31:0] cnt, input logic [15:0] pc, input logic halt);
    retire_t r;
    r.cnt = cnt;
    r.pc = pc;
    r.halt = halt;
    retireQ.push_back(r);
  endtask

  task automatic expWrite(input logic [15:0] addr, input logic [15:0] data);
    write_t w;
    w.addr = addr;
    w.data = data;
    writeQ.push_back(w);
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic cyclesToRetire(output int n);
    logic [31:0] c0;
    c0 = instrCount;
    n = 0;
    while (instrCount == c0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic waitHalt(input string name);
    int n;
    n = 0;
    while (!halted && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, {31'd0, halted}, 32'd1);
    checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: retirements, completed writes and accepted outputs against the queues.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        lastCnt = instrCount;
      end else begin
        if (instrCount != lastCnt) begin
          lastCnt = instrCount;
          if (retireQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected retire: count %0d", instrCount);
          end else begin
            retire_t r;
            r = retireQ.pop_front();
            checkOutput("retire count", instrCount, r.cnt);
            checkOutput("retire pc", {16'd0, memAddr}, {16'd0, r.pc});
            checkOutput("retire halted", {31'd0, halted}, {31'd0, r.halt});
          end
        end
        if (memReq && memWe && memAck) begin
          if (writeQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected write: addr %0h data %0h", memAddr, memWdata);
          end else begin
            write_t w;
            w = writeQ.pop_front();
            checkOutput("write addr", {16'd0, memAddr}, {16'd0, w.addr});
            checkOutput("write data", {16'd0, memWdata}, {16'd0, w.data});
          end
        end
        if (outValid && outReady) begin
          if (outQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected output: data %0h", outData);
          end else begin
            logic [15:0] e;
            e = outQ.pop_front();
            checkOutput("out data", {16'd0, outData}, {16'd0, e});
          end
        end
        if (inReady) inPulses++;
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int cyc;
    int n;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("reset mem_we", {31'd0, memWe}, 32'd0);
    checkOutput("reset mem_addr", {16'd0, memAddr}, 32'd5);
    checkOutput("reset mem_wdata", {16'd0, memWdata}, 32'd0);
    checkOutput("reset in_ready", {31'd0, inReady}, 32'd0);
    checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset out_data", {16'd0, outData}, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset instr_count", instrCount, 32'd0);
    reset = 1'b1;

    $display("[TB] segment 1: basic subtract, zero-wait memory");
    loadWord(5, 20);   loadWord(20, 7);
    loadWord(6, 21);   loadWord(21, 8);
    loadWord(7, 22);   loadWord(22, 1);
    loadWord(8, 23);   loadWord(23, 1);
    loadWord(9, 24);   loadWord(24, 1);
    loadWord(10, 25);  loadWord(25, 1);
    loadWord(11, 0);
    expWrite(20, 7); expRetire(1, 6, 0);
    expWrite(21, 1); expRetire(2, 7, 0);
    expWrite(22, 0); expRetire(3, 8, 0);
    expWrite(23, 1); expRetire(4, 9, 0);
    expWrite(24, 0); expRetire(5, 10, 0);
    expWrite(25, 1); expRetire(6, 11, 0);
    expRetire(7, 11, 1);
    applyStimulus();
    checkOutput("seg1 busy after start", {31'd0, busy}, 32'd1);
    cyclesToRetire(cyc);
    checkOutput("seg1 memory operand cycles", cyc, 32'd4);
    waitHalt("seg1 halt");

    $display("[TB] segment 2: borrow skip with 3-cycle ack delay");
    ackDelay = 3;
    loadWord(5, 20);      loadWord(20, 3);
    loadWord(7, 27);      loadWord(27, 16'h0012);
    loadWord(8, 0);
    loadWord(16'hFFF1, 28); loadWord(28, 16'hFFF1);
    loadWord(16'hFFF2, 0);
    expWrite(20, 16'hFFF9); expRetire(8, 7, 0);
    expWrite(27, 16'h0019); expRetire(9, 8, 0);
    expRetire(10, 16'hFFF1, 0);
    expWrite(28, 2);        expRetire(11, 16'hFFF2, 0);
    expRetire(12, 16'hFFF2, 1);
    applyStimulus();
    cyclesToRetire(cyc);
    checkOutput("seg2 stalled instruction cycles", cyc, 32'd13);
    waitHalt("seg2 halt");
    ackDelay = 0;

    $display("[TB] segment 3: PC operand jump");
    loadWord(5, 0);
    loadWord(16'h16, 29); loadWord(29, 16'h0025);
    loadWord(16'h17, 0);
    loadWord(8, 30);      loadWord(30, 8);
    loadWord(9, 0);
    expRetire(13, 16'h16, 0);
    expWrite(29, 16'h0010); expRetire(14, 16'h17, 0);
    expRetire(15, 8, 0);
    expWrite(30, 1);        expRetire(16, 9, 0);
    expRetire(17, 9, 1);
    applyStimulus();
    cyclesToRetire(cyc);
    checkOutput("seg3 special operand cycles", cyc, 32'd3);
    waitHalt("seg3 halt");

    $display("[TB] segment 4: input stall and output back-pressure");
    loadWord(5, 3);
    loadWord(6, 4);
    loadWord(8, 31); loadWord(31, 0);
    loadWord(9, 0);
    expRetire(18, 6, 0);
    outQ.push_back(16'hFFFF); expRetire(19, 8, 0);
    expWrite(31, 1);          expRetire(20, 9, 0);
    expRetire(21, 9, 1);
    inPulses = 0;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      checkOutput("seg4 in_ready while in_valid low", {31'd0, inReady}, 32'd0);
    end
    checkOutput("seg4 stalled count", instrCount, 32'd17);
    inValid = 1'b1;
    inData  = 16'd9;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inData  = 16'h1234;
    n = 0;
    while (!outValid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("seg4 out_valid reached", {31'd0, outValid}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      checkOutput("seg4 out_valid held", {31'd0, outValid}, 32'd1);
      checkOutput("seg4 out_data stable", {16'd0, outData}, 32'h0000FFFF);
      checkOutput("seg4 no retire while held", instrCount, 32'd18);
    end
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    waitHalt("seg4 halt");
    checkOutput("seg4 in_ready pulses", inPulses, 32'd1);

    $display("[TB] segment 5: restart from halt, then reset mid-write");
    loadWord(5, 20); loadWord(20, 50);
    holdWrite = 1'b1;
    applyStimulus();
    checkOutput("seg5 restart halted", {31'd0, halted}, 32'd0);
    checkOutput("seg5 restart busy", {31'd0, busy}, 32'd1);
    checkOutput("seg5 restart pc", {16'd0, memAddr}, 32'd5);
    checkOutput("seg5 count kept", instrCount, 32'd21);
    n = 0;
    while (!(memReq && memWe) && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("seg5 write pending", {31'd0, memReq && memWe}, 32'd1);
    checkOutput("seg5 pending addr", {16'd0, memAddr}, 32'd20);
    checkOutput("seg5 pending data", {16'd0, memWdata}, 32'd42);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("abort mem_we", {31'd0, memWe}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort halted", {31'd0, halted}, 32'd0);
    checkOutput("abort pc", {16'd0, memAddr}, 32'd5);
    checkOutput("abort count", instrCount, 32'd0);
    checkOutput("abort memory untouched", {16'd0, mem[20]}, 32'd50);
    @(posedge clock);
    #1;
    reset = 1'b1;
    holdWrite = 1'b0;
    loadWord(6, 32); loadWord(32, 51);
    loadWord(7, 0);
    expWrite(20, 50); expRetire(1, 6, 0);
    expWrite(32, 1);  expRetire(2, 7, 0);
    expRetire(3, 7, 1);
    applyStimulus();
    waitHalt("seg5 halt");

    repeat (2) @(posedge clock);
    #1;
    checkOutput("retire queue drained", retireQ.size(), 32'd0);
    checkOutput("write queue drained", writeQ.size(), 32'd0);
    checkOutput("output queue drained", outQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
